// File: rtl/lsu.sv
// Load/store unit: single-outstanding memory handshake with store lane alignment,
// load extraction/extension, and accept-time / response-timeout exceptions.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_done,
  output logic        o_exc,
  output logic [1:0]  o_exc_code
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  localparam logic [1:0] ExcNone     = 2'b00;
  localparam logic [1:0] ExcMisalign = 2'b01;
  localparam logic [1:0] ExcIllegal  = 2'b10;
  localparam logic [1:0] ExcTimeout  = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  exc_q, exc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        is_load_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;

  logic        accept;
  logic        capture;
  logic        wb_load;
  logic        acc_illegal;
  logic        acc_misal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign accept = i_valid & (state_q == StIdle) & (i_load | i_store);

  // Accept-time checks look at the incoming instruction, not the registered copy.
  always_comb begin
    acc_illegal = (i_funct3 == 3'b011) | (i_funct3 == 3'b110) | (i_funct3 == 3'b111) |
                  (i_store & i_funct3[2]);
    acc_misal   = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                  ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    wb_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          capture = 1'b1;
          if (acc_illegal) begin
            exc_d   = ExcIllegal;
            state_d = StResp;
          end else if (acc_misal) begin
            exc_d   = ExcMisalign;
            state_d = StResp;
          end else begin
            exc_d   = ExcNone;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (i_mem_gnt) begin
          if (is_load_q) begin
            cnt_d   = 16'd0;
            state_d = StWait;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        // A response on the timeout cycle still completes the load normally.
        if (i_mem_rvalid) begin
          wb_load = 1'b1;
          state_d = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          exc_d   = ExcTimeout;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      exc_q   <= ExcNone;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q    <= 32'd0;
      funct3_q  <= 3'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      is_load_q <= 1'b0;
    end else if (capture) begin
      addr_q    <= i_addr;
      funct3_q  <= i_funct3;
      wdata_q   <= i_wdata;
      rd_q      <= i_rd;
      is_load_q <= i_load;
    end
  end

  always_comb begin
    ld_byte = 8'd0;
    case (addr_q[1:0])
      2'b00:   ld_byte = i_mem_rdata[7:0];
      2'b01:   ld_byte = i_mem_rdata[15:8];
      2'b10:   ld_byte = i_mem_rdata[23:16];
      default: ld_byte = i_mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    ld_ext  = i_mem_rdata;
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = i_mem_rdata;
    endcase
  end

  // Write-back registers hold their value until the next successful load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_data_q <= 32'd0;
      wb_rd_q   <= 5'd0;
    end else if (wb_load) begin
      wb_data_q <= ld_ext;
      wb_rd_q   <= rd_q;
    end
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = 32'd0;
    o_mem_mask  = 4'd0;
    if (state_q == StReq) begin
      o_mem_req  = 1'b1;
      o_mem_addr = {addr_q[31:2], 2'b00};
      o_mem_wen  = ~is_load_q;
      case (funct3_q[1:0])
        2'b00: begin
          o_mem_mask  = 4'b0001 << addr_q[1:0];
          o_mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          o_mem_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
          o_mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          o_mem_mask  = 4'b1111;
          o_mem_wdata = wdata_q;
        end
      endcase
    end
  end

  always_comb begin
    o_ready    = (state_q == StIdle);
    o_done     = (state_q == StResp);
    o_exc      = (state_q == StResp) & (exc_q != ExcNone);
    o_exc_code = (state_q == StResp) ? exc_q : ExcNone;
    o_wb_valid = (state_q == StResp) & is_load_q & (exc_q == ExcNone);
    o_wb_data  = wb_data_q;
    o_wb_rd    = wb_rd_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, reset-in-WAIT sequence and
// randomized transactions checked against a byte-level reference model.
module tb_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, load, store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        ready;
  logic        mem_req, mem_gnt, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;
  logic        wb_valid, done, exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  exc_code;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_load      (load),
    .i_store     (store),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_rd        (rd),
    .o_mem_req   (mem_req),
    .i_mem_gnt   (mem_gnt),
    .o_mem_addr  (mem_addr),
    .o_mem_wen   (mem_wen),
    .o_mem_wdata (mem_wdata),
    .o_mem_mask  (mem_mask),
    .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata (mem_rdata),
    .o_wb_valid  (wb_valid),
    .o_wb_rd     (wb_rd),
    .o_wb_data   (wb_data),
    .o_done      (done),
    .o_exc       (exc),
    .o_exc_code  (exc_code)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;     // -1: response never arrives
    logic [1:0]  exp_code;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_wb;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_wb;
  logic [4:0]  last_rd;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [4:0] r,
                              input logic [31:0] rdat, input int gd, input int rvd,
                              input logic [1:0] code, input logic [3:0] m,
                              input logic [31:0] mwd, input logic [31:0] wb);
    vec_t v;
    v.ld = ld; v.st = ~ld; v.f3 = f3; v.addr = a; v.wdata = wd; v.rd = r; v.rdata = rdat;
    v.gnt_dly = gd; v.rv_dly = rvd; v.exp_code = code; v.exp_mask = m;
    v.exp_mwdata = mwd; v.exp_wb = wb;
    return v;
  endfunction

  // Reference model: access size in bytes, modular alignment, byte-lane arithmetic.
  function automatic vec_t model(input vec_t vin);
    vec_t        v;
    int          size;
    int          off;
    int          m;
    logic [63:0] val;
    v = vin;
    size = 1 << v.f3[1:0];
    off = v.addr % 4;
    v.exp_code = 2'b00;
    if (v.f3 == 3'd3 || v.f3 == 3'd6 || v.f3 == 3'd7 || (v.st && v.f3[2]))
      v.exp_code = 2'b10;
    else if ((v.addr % size) != 0)
      v.exp_code = 2'b01;
    else if (v.ld && v.rv_dly < 0)
      v.exp_code = 2'b11;
    m = ((1 << size) - 1) << off;
    v.exp_mask = m[3:0];
    v.exp_mwdata = 32'd0;
    for (int i = 0; i < 4; i++) v.exp_mwdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
    val = {32'd0, v.rdata} >> (8 * off);
    if (size < 4) begin
      val = val & ((64'd1 << (8 * size)) - 64'd1);
      if (!v.f3[2] && val[8*size-1]) val = val - (64'd1 << (8 * size));
    end
    v.exp_wb = val[31:0];
    return v;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after RESP.
  task automatic do_txn(input vec_t v);
    chk("ready_idle", ready, 1);
    valid = 1'b1; load = v.ld; store = v.st; funct3 = v.f3;
    addr = v.addr; wdata = v.wdata; rd = v.rd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    valid = 1'b0; load = 1'b0; store = 1'b0;
    addr = $urandom; wdata = $urandom; rd = 5'($urandom);
    chk("ready_busy", ready, 0);
    if (v.exp_code == 2'b01 || v.exp_code == 2'b10) begin
      chk("acc_exc_req", mem_req, 0);
      chk("acc_exc_done", done, 1);
      chk("acc_exc", exc, 1);
      chk("acc_exc_code", exc_code, v.exp_code);
      chk("acc_exc_wbv", wb_valid, 0);
    end else begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        chk("req", mem_req, 1);
        chk("req_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        chk("req_wen", mem_wen, v.st);
        if (v.st) begin
          chk("req_mask", mem_mask, v.exp_mask);
          chk("req_wdata", mem_wdata, v.exp_mwdata);
        end
        chk("req_done", done, 0);
        mem_gnt = (k == v.gnt_dly);
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (v.st) begin
        chk("st_done", done, 1);
        chk("st_exc", exc, 0);
        chk("st_wbv", wb_valid, 0);
        chk("st_req_low", mem_req, 0);
      end else if (v.rv_dly >= 0) begin
        for (int j = 0; j <= v.rv_dly; j++) begin
          chk("wait_done", done, 0);
          chk("wait_req", mem_req, 0);
          mem_rvalid = (j == v.rv_dly);
          mem_rdata = (j == v.rv_dly) ? v.rdata : $urandom;
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
        chk("ld_done", done, 1);
        chk("ld_exc", exc, 0);
        chk("ld_code", exc_code, 0);
        chk("ld_wbv", wb_valid, 1);
        last_wb = v.exp_wb;
        last_rd = v.rd;
      end else begin
        for (int j = 0; j <= int'(TO); j++) begin
          chk("to_done_early", done, 0);
          chk("to_wbv_early", wb_valid, 0);
          @(negedge clk);
        end
        chk("to_done", done, 1);
        chk("to_exc", exc, 1);
        chk("to_code", exc_code, 2'b11);
        chk("to_wbv", wb_valid, 0);
      end
    end
    chk("wb_data", wb_data, last_wb);
    chk("wb_rd", wb_rd, last_rd);
    @(negedge clk);
    chk("ready_after", ready, 1);
    chk("done_pulse", done, 0);
    chk("exc_pulse", exc, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_mask", mem_mask, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_done", done, 0);
    chk("rst_exc", exc, 0);
    chk("rst_code", exc_code, 0);
  endtask

  initial begin
    vec_t r;
    rst_n = 1'b0; valid = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    last_wb = 32'd0; last_rd = 5'd0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // i_valid without load/store is ignored
    valid = 1'b1; funct3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    valid = 1'b0;
    chk("nop_ready", ready, 1);
    chk("nop_req", mem_req, 0);
    chk("nop_done", done, 0);

    tbl.push_back(mk(0, 3'b010, 32'h1000_0006, 32'hAABB_CCDD, 5'd1, 32'h0, 0, 0,
                     2'b01, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 3'b000, 32'h1000_0003, 32'h1234_5678, 5'd1, 32'h0, 3, 0,
                     2'b00, 4'b1000, 32'h7878_7878, 32'h0));
    tbl.push_back(mk(1, 3'b000, 32'h20, 32'h0, 5'd3, 32'h80FF_7F01, 0, 0,
                     2'b00, 4'h0, 32'h0, 32'h0000_0001));
    tbl.push_back(mk(1, 3'b000, 32'h21, 32'h0, 5'd3, 32'h80FF_7F01, 1, 2,
                     2'b00, 4'h0, 32'h0, 32'h0000_007F));
    tbl.push_back(mk(1, 3'b000, 32'h22, 32'h0, 5'd3, 32'h80FF_7F01, 0, 1,
                     2'b00, 4'h0, 32'h0, 32'hFFFF_FFFF));
    tbl.push_back(mk(1, 3'b000, 32'h23, 32'h0, 5'd3, 32'h80FF_7F01, 2, 0,
                     2'b00, 4'h0, 32'h0, 32'hFFFF_FF80));
    tbl.push_back(mk(1, 3'b100, 32'h23, 32'h0, 5'd4, 32'h80FF_7F01, 0, 0,
                     2'b00, 4'h0, 32'h0, 32'h0000_0080));
    tbl.push_back(mk(1, 3'b001, 32'h22, 32'h0, 5'd5, 32'h8001_1234, 0, 0,
                     2'b00, 4'h0, 32'h0, 32'hFFFF_8001));
    tbl.push_back(mk(1, 3'b101, 32'h22, 32'h0, 5'd7, 32'h8001_1234, 0, 3,
                     2'b00, 4'h0, 32'h0, 32'h0000_8001));
    tbl.push_back(mk(1, 3'b010, 32'h24, 32'h0, 5'd0, 32'hDEAD_BEEF, 0, 0,
                     2'b00, 4'h0, 32'h0, 32'hDEAD_BEEF));
    tbl.push_back(mk(1, 3'b011, 32'h24, 32'h0, 5'd8, 32'h0, 0, 0,
                     2'b10, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 3'b100, 32'h24, 32'h0, 5'd8, 32'h0, 0, 0,
                     2'b10, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 3'b001, 32'h42, 32'h1234_ABCD, 5'd8, 32'h0, 1, 0,
                     2'b00, 4'b1100, 32'hABCD_ABCD, 32'h0));
    tbl.push_back(mk(1, 3'b001, 32'h21, 32'h0, 5'd9, 32'h0, 0, 0,
                     2'b01, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 3'b010, 32'h30, 32'h0, 5'd10, 32'h0, 0, -1,
                     2'b11, 4'h0, 32'h0, 32'h0));
    foreach (tbl[i]) do_txn(tbl[i]);

    // Reset while waiting for a response, then a stray rvalid
    valid = 1'b1; load = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h100; rd = 5'd9;
    @(negedge clk);
    valid = 1'b0; load = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", mem_req, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    chk("rw_no_done", done, 0);
    rst_n = 1'b1;
    last_wb = 32'd0; last_rd = 5'd0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray_done", done, 0);
    chk("stray_wbv", wb_valid, 0);
    chk("stray_ready", ready, 1);
    chk("stray_wbdata", wb_data, 0);
    do_txn(mk(1, 3'b010, 32'h104, 32'h0, 5'd11, 32'hCAFE_F00D, 0, 0,
              2'b00, 4'h0, 32'h0, 32'hCAFE_F00D));

    for (int n = 0; n < 150; n++) begin
      r.ld = 1'($urandom_range(0, 1));
      r.st = ~r.ld;
      r.f3 = 3'($urandom_range(0, 7));
      r.addr = $urandom;
      if ($urandom_range(0, 1) == 1) r.addr[1:0] = 2'b00;
      r.wdata = $urandom;
      r.rd = 5'($urandom);
      r.rdata = $urandom;
      r.gnt_dly = $urandom_range(0, 3);
      r.rv_dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      do_txn(model(r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
